// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: button-driven entry sequencer for set-time, set-date and
// set-alarm. Range-checks each field, stages it, and commits the whole set
// with a one-cycle overwrite pulse to the time-keeping datapath.
module clock_set_ctrl #(
   parameter int unsigned TIMEOUT_S = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick_1hz,
   input  logic        btn_time,
   input  logic        btn_date,
   input  logic        btn_alarm,
   input  logic        btn_next,
   input  logic        btn_abort,
   input  logic [6:0]  value_in,
   output logic [16:0] time_set,
   output logic        time_ow,
   output logic [20:0] date_set,
   output logic        date_ow,
   output logic [10:0] alarm_set,
   output logic        alarm_ow,
   output logic [1:0]  state,
   output logic [1:0]  step,
   output logic        err,
   output logic        timeout
);

   localparam int unsigned CNT_W = 6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_TIME = 2'd1,
      S_DATE = 2'd2,
      S_ALRM = 2'd3
   } state_t;

   state_t             cur_state;
   logic [1:0]         step_q;
   logic [CNT_W-1:0]   idle_cnt;
   logic [4:0]         stg_hour;
   logic [5:0]         stg_min;
   logic [11:0]        stg_year;
   logic [3:0]         stg_month;

   logic [4:0]         dim_c;
   logic               value_ok_c;
   logic               last_step_c;

   assign state = cur_state;
   assign step  = step_q;

   // Days in the staged month, leap years being every year divisible by 4
   always_comb begin
      dim_c = 5'd31;
      case (stg_month)
         4'd4, 4'd6, 4'd9, 4'd11: dim_c = 5'd30;
         4'd2:                    dim_c = (stg_year[1:0] == 2'd0) ? 5'd29 : 5'd28;
         default:                 dim_c = 5'd31;
      endcase
   end

   // Range check of value_in for the field currently being entered
   always_comb begin
      value_ok_c  = 1'b0;
      last_step_c = (cur_state == S_DATE) ? (step_q == 2'd2) : (step_q == 2'd1);
      case (cur_state)
         S_TIME, S_ALRM: begin
            if (step_q == 2'd0) value_ok_c = (value_in <= 7'd23);
            else                value_ok_c = (value_in <= 7'd59);
         end
         S_DATE: begin
            case (step_q)
               2'd0:    value_ok_c = (value_in <= 7'd99);
               2'd1:    value_ok_c = (value_in >= 7'd1) && (value_in <= 7'd12);
               default: value_ok_c = (value_in >= 7'd1) && (value_in <= {2'b00, dim_c});
            endcase
         end
         default: value_ok_c = 1'b0;
      endcase
   end

   // Entry FSM, staging, commit registers and inactivity timeout
   always_ff @(posedge clk) begin
      if (rst) begin
         cur_state <= S_IDLE;
         step_q    <= 2'd0;
         idle_cnt  <= '0;
         stg_hour  <= '0;
         stg_min   <= '0;
         stg_year  <= '0;
         stg_month <= 4'd1;
         time_set  <= '0;
         date_set  <= {5'd1, 4'd1, 12'd0};
         alarm_set <= '0;
         time_ow   <= 1'b0;
         date_ow   <= 1'b0;
         alarm_ow  <= 1'b0;
         err       <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         time_ow  <= 1'b0;
         date_ow  <= 1'b0;
         alarm_ow <= 1'b0;
         err      <= 1'b0;
         timeout  <= 1'b0;

         if (cur_state == S_IDLE) begin
            idle_cnt <= '0;
            step_q   <= 2'd0;
            if (btn_time) begin
               cur_state <= S_TIME;
               stg_hour  <= time_set[16:12];
               stg_min   <= time_set[11:6];
            end else if (btn_date) begin
               cur_state <= S_DATE;
               stg_month <= date_set[15:12];
               stg_year  <= date_set[11:0];
            end else if (btn_alarm) begin
               cur_state <= S_ALRM;
               stg_hour  <= alarm_set[10:6];
               stg_min   <= alarm_set[5:0];
            end
         end else if (btn_abort) begin
            cur_state <= S_IDLE;
            step_q    <= 2'd0;
            idle_cnt  <= '0;
         end else if (btn_next) begin
            idle_cnt <= '0;
            if (!value_ok_c) begin
               err <= 1'b1;
            end else if (last_step_c) begin
               // Final field goes straight to the output register with the staged ones
               cur_state <= S_IDLE;
               step_q    <= 2'd0;
               case (cur_state)
                  S_TIME: begin
                     time_set <= {stg_hour, value_in[5:0], 6'd0};
                     time_ow  <= 1'b1;
                  end
                  S_DATE: begin
                     date_set <= {value_in[4:0], stg_month, stg_year};
                     date_ow  <= 1'b1;
                  end
                  default: begin
                     alarm_set <= {stg_hour, value_in[5:0]};
                     alarm_ow  <= 1'b1;
                  end
               endcase
            end else begin
               step_q <= step_q + 2'd1;
               if (cur_state == S_DATE) begin
                  if (step_q == 2'd0) stg_year  <= {5'd0, value_in};
                  else                stg_month <= value_in[3:0];
               end else begin
                  stg_hour <= value_in[4:0];
               end
            end
         end else if (tick_1hz) begin
            if (idle_cnt + CNT_W'(1) >= CNT_W'(TIMEOUT_S)) begin
               cur_state <= S_IDLE;
               step_q    <= 2'd0;
               idle_cnt  <= '0;
               timeout   <= 1'b1;
            end else begin
               idle_cnt <= idle_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: a field-list model predicts every
// output each cycle; literal checks at key points pin the model itself.
module tb_clock_set_ctrl;

   localparam int TO = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tick_1hz = 1'b0;
   logic        btn_time = 1'b0, btn_date = 1'b0, btn_alarm = 1'b0;
   logic        btn_next = 1'b0, btn_abort = 1'b0;
   logic [6:0]  value_in = 7'd0;
   logic [16:0] time_set;
   logic        time_ow;
   logic [20:0] date_set;
   logic        date_ow;
   logic [10:0] alarm_set;
   logic        alarm_ow;
   logic [1:0]  state;
   logic [1:0]  step;
   logic        err;
   logic        timeout;

   int checks = 0;
   int failures = 0;

   clock_set_ctrl #(.TIMEOUT_S(TO)) dut (
      .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
      .btn_time(btn_time), .btn_date(btn_date), .btn_alarm(btn_alarm),
      .btn_next(btn_next), .btn_abort(btn_abort), .value_in(value_in),
      .time_set(time_set), .time_ow(time_ow),
      .date_set(date_set), .date_ow(date_ow),
      .alarm_set(alarm_set), .alarm_ow(alarm_ow),
      .state(state), .step(step), .err(err), .timeout(timeout)
   );

   always #5 clk = ~clk;

   // Model: mode 0 idle, 1 time, 2 date, 3 alarm; fields entered into stg[]
   int m_mode = 0, m_step = 0, m_cnt = 0;
   int stg[3];
   int c_time[2]  = '{0, 0};       // hour, minute
   int c_date[3]  = '{0, 1, 1};    // year, month, day
   int c_alarm[2] = '{0, 0};       // hour, minute
   int e_tow = 0, e_dow = 0, e_aow = 0, e_err = 0, e_to = 0;

   function automatic int nfields(int mode);
      return (mode == 2) ? 3 : 2;
   endfunction

   function automatic int days_in(int mo, int yr);
      if (mo == 2) return (yr % 4 == 0) ? 29 : 28;
      if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
      return 31;
   endfunction

   function automatic bit legal(int mode, int idx, int v, int yr, int mo);
      if (mode == 2) begin
         if (idx == 0) return v <= 99;
         if (idx == 1) return v >= 1 && v <= 12;
         return v >= 1 && v <= days_in(mo, yr);
      end
      return (idx == 0) ? (v <= 23) : (v <= 59);
   endfunction

   task automatic go_idle();
      m_mode = 0; m_step = 0; m_cnt = 0;
   endtask

   task automatic model_update();
      e_tow = 0; e_dow = 0; e_aow = 0; e_err = 0; e_to = 0;
      if (rst) begin
         go_idle();
         c_time = '{0, 0}; c_date = '{0, 1, 1}; c_alarm = '{0, 0};
      end else if (m_mode == 0) begin
         if (btn_time)       m_mode = 1;
         else if (btn_date)  m_mode = 2;
         else if (btn_alarm) m_mode = 3;
         m_step = 0; m_cnt = 0;
      end else if (btn_abort) begin
         go_idle();
      end else if (btn_next) begin
         m_cnt = 0;
         if (!legal(m_mode, m_step, int'(value_in), stg[0], stg[1])) e_err = 1;
         else begin
            stg[m_step] = int'(value_in);
            if (m_step == nfields(m_mode) - 1) begin
               if (m_mode == 1) begin c_time  = '{stg[0], stg[1]};         e_tow = 1; end
               if (m_mode == 2) begin c_date  = '{stg[0], stg[1], stg[2]}; e_dow = 1; end
               if (m_mode == 3) begin c_alarm = '{stg[0], stg[1]};         e_aow = 1; end
               go_idle();
            end else m_step++;
         end
      end else if (tick_1hz) begin
         m_cnt++;
         if (m_cnt >= TO) begin e_to = 1; go_idle(); end
      end
   endtask

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // Per-cycle compare of every output against the model
   always @(posedge clk) begin
      model_update();
      #1;
      chk("state", int'(state), m_mode);
      chk("step", int'(step), m_step);
      chk("time_set", int'(time_set), c_time[0] * 4096 + c_time[1] * 64);
      chk("date_set", int'(date_set), c_date[2] * 65536 + c_date[1] * 4096 + c_date[0]);
      chk("alarm_set", int'(alarm_set), c_alarm[0] * 64 + c_alarm[1]);
      chk("time_ow", int'(time_ow), e_tow);
      chk("date_ow", int'(date_ow), e_dow);
      chk("alarm_ow", int'(alarm_ow), e_aow);
      chk("err", int'(err), e_err);
      chk("timeout", int'(timeout), e_to);
   end

   // One clock with the given buttons {time,date,alarm,next,abort,tick} and value
   task automatic press(input logic [5:0] b, input int v);
      {btn_time, btn_date, btn_alarm, btn_next, btn_abort, tick_1hz} = b;
      value_in = 7'(v);
      @(posedge clk); #2;
      {btn_time, btn_date, btn_alarm, btn_next, btn_abort, tick_1hz} = 6'b0;
   endtask

   localparam logic [5:0] B_TIME = 6'b100000, B_DATE = 6'b010000, B_ALRM = 6'b001000;
   localparam logic [5:0] B_NEXT = 6'b000100, B_ABRT = 6'b000010, B_TICK = 6'b000001;
   localparam logic [5:0] B_NONE = 6'b000000;

   initial begin
      repeat (2) @(posedge clk);
      #2;
      chk("lit_reset_state", int'(state), 0);
      chk("lit_reset_date", int'(date_set), 'h11000);
      chk("lit_reset_time", int'(time_set), 0);
      rst = 1'b0;
      press(B_NEXT, 5);                 // ignored in idle

      // Time entry 23:59
      press(B_TIME, 0);
      press(B_NEXT, 23);
      press(B_NEXT, 59);
      chk("lit_time_ow", int'(time_ow), 1);
      chk("lit_time_set", int'(time_set), 'h17EC0);
      chk("lit_time_state", int'(state), 0);
      press(B_NONE, 0);

      // Leap date 24/2/29
      press(B_DATE, 0);
      press(B_NEXT, 24);
      press(B_NEXT, 2);
      press(B_NEXT, 29);
      chk("lit_date_ow", int'(date_ow), 1);
      chk("lit_date_set", int'(date_set), 'h1D2018);

      // Non-leap year 23: day 29 rejected, 28 commits
      press(B_DATE, 0);
      press(B_NEXT, 23);
      press(B_NEXT, 2);
      press(B_NEXT, 29);
      chk("lit_err_day29", int'(err), 1);
      chk("lit_step_hold", int'(step), 2);
      press(B_NEXT, 28);
      chk("lit_date_28", int'(date_set), 'h1C2017);

      // Alarm hour 24 rejected, then 07:30
      press(B_ALRM, 0);
      press(B_NEXT, 24);
      chk("lit_err_hour24", int'(err), 1);
      chk("lit_step0", int'(step), 0);
      press(B_NEXT, 7);
      press(B_NEXT, 60);
      press(B_NEXT, 30);
      chk("lit_alarm_set", int'(alarm_set), 7 * 64 + 30);

      // Month 0/13 and day 31 in April rejected
      press(B_DATE, 0);
      press(B_NEXT, 100);
      press(B_NEXT, 50);
      press(B_NEXT, 0);
      press(B_NEXT, 13);
      press(B_NEXT, 4);
      press(B_NEXT, 31);
      press(B_NEXT, 0);
      press(B_NEXT, 30);

      // Abort coinciding with next
      press(B_TIME, 0);
      press(B_NEXT, 5);
      press(B_ABRT | B_NEXT, 9);
      chk("lit_abort_state", int'(state), 0);
      chk("lit_abort_time", int'(time_set), 'h17EC0);
      press(B_NONE, 0);

      // Timeout with restart by btn_next on the 2nd tick
      press(B_TICK, 0);                 // idle tick ignored
      press(B_DATE, 0);
      press(B_TICK, 0);
      press(B_TICK | B_NEXT, 10);
      press(B_TICK, 0);
      press(B_NONE, 0);
      press(B_TICK, 0);
      chk("lit_no_timeout_yet", int'(timeout), 0);
      press(B_TICK, 0);
      chk("lit_timeout", int'(timeout), 1);
      chk("lit_timeout_date", int'(date_set), 'h1E4032);
      press(B_NONE, 0);

      // Start priority, start ignored mid-entry, abort+tick
      press(B_TIME | B_ALRM, 0);
      chk("lit_prio", int'(state), 1);
      press(B_DATE, 0);
      press(B_TICK, 0);
      press(B_TICK, 0);
      press(B_TICK | B_ABRT, 0);
      press(B_ALRM, 0);
      press(B_ABRT, 0);

      // Reset at step 1
      press(B_TIME, 0);
      press(B_NEXT, 5);
      rst = 1'b1;
      press(B_NEXT, 6);
      chk("lit_rst_state", int'(state), 0);
      chk("lit_rst_time", int'(time_set), 0);
      chk("lit_rst_ow", int'(time_ow), 0);
      rst = 1'b0;
      press(B_NONE, 0);
      press(B_TIME, 0);
      press(B_NEXT, 0);
      press(B_NEXT, 0);
      press(B_NONE, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Button-driven entry sequencer for the digital clock's set-time, set-date and set-alarm operations. It walks the user through each field, range-checks the switch value (including month length and leap years), stages the fields, and commits them with a single-cycle overwrite pulse to the clockwork, calendar and alarm blocks. It sits between the debouncers/switches and the time-keeping datapath and owns all write access to it.

## Interface
- `TIMEOUT_S`, default 30: number of `tick_1hz` pulses with no accepted button before an entry is abandoned (1..63).
- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-high.
- `tick_1hz`  in  1  one-cycle enable, once per second.
- `btn_time`, `btn_date`, `btn_alarm`  in  1 each  debounced one-cycle start requests.
- `btn_next`  in  1  debounced one-cycle confirm of the current field.
- `btn_abort`  in  1  debounced one-cycle cancel.
- `value_in`  in  7  field value from the switches, unsigned.
- `time_set`  out  17  `{hour[4:0],min[5:0],sec[5:0]}`; `sec` is always 0.
- `time_ow`  out  1  one-cycle commit pulse for `time_set`.
- `date_set`  out  21  `{day[4:0],month[3:0],year[11:0]}`.
- `date_ow`  out  1  one-cycle commit pulse for `date_set`.
- `alarm_set`  out  11  `{hour[4:0],min[5:0]}`.
- `alarm_ow`  out  1  one-cycle commit pulse for `alarm_set`.
- `state`  out  2  0 IDLE, 1 TIME, 2 DATE, 3 ALRM.
- `step`  out  2  index of the field being entered.
- `err`  out  1  one-cycle pulse: `btn_next` rejected because the value is out of range.
- `timeout`  out  1  one-cycle pulse: entry abandoned by the timeout.

## Operation
- **IDLE**
  - A start button moves the FSM to TIME, DATE or ALRM and sets `step` to 0.
  - If start buttons arrive in the same cycle, priority is `btn_time` > `btn_date` > `btn_alarm`.
  - `btn_next` and `btn_abort` are ignored.
- **Field order**
  - TIME: hour (step 0), then minute (step 1).
  - DATE: year (0), then month (1), then day (2).
  - ALRM: hour (0), then minute (1).
- **Valid ranges**
  - hour: 0..23.
  - minute: 0..59.
  - year: 0..99, zero-extended to 12 bits.
  - month: 1..12.
  - day: 1..`dim`, where `dim` is 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; and 29 for month 2 if `year[1:0]==0`, otherwise 28.
  - Day is checked against the month and year already staged in this entry.
- **btn_next, valid value:** latch `value_in` into a staging register and increment `step`. On the last step, commit instead: copy staging to the output register, pulse the matching `*_ow`, and go to IDLE.
- **btn_next, invalid value:** pulse `err`; `step` and staging are unchanged.
- **Staging**
  - Staging registers are internal.
  - Outputs change only on commit, so an abort or timeout leaves `*_set` untouched.
  - On entry start, staging is preloaded from the current output register.
- **btn_abort** in a non-IDLE state: go to IDLE, no `*_ow`. If it coincides with `btn_next`, abort wins.
- **Start buttons** in a non-IDLE state are ignored.
- **Timeout**
  - The idle counter clears on entering a non-IDLE state and on any accepted `btn_next`, including a rejected one.
  - It increments on `tick_1hz` while non-IDLE.
  - When it reaches `TIMEOUT_S`: go to IDLE and pulse `timeout`, no commit.
  - If `btn_next`/`btn_abort` coincide with the expiring tick, the button wins and the counter clears.

## Timing
- **Reset values:**
  - `state`=IDLE, `step`=0.
  - `time_set`=0, `alarm_set`=0.
  - `date_set`=`{5'd1,4'd1,12'd0}`.
  - `time_ow`, `date_ow`, `alarm_ow`, `err`, `timeout` = 0; timeout counter 0.
- Reset mid-entry returns to IDLE at the next edge, with no `*_ow` pulse and staging discarded.
- All outputs are registered. A button sampled at edge N takes effect in `state`/`step`/`err` after edge N.
- On commit, `*_set` and `*_ow` change at the same edge. `*_ow` is high for exactly one cycle and `*_set` holds afterwards.
- `state` reads IDLE in the same cycle `*_ow` is high, so downstream may sample `*_set` on `*_ow`.
- A new start button is accepted the cycle after a commit, abort or timeout.
- `err` and `timeout` are each high for exactly one cycle per event.
- Minimum entry time is `step_count`+1 button cycles.

## Test plan
- **Time entry:** `btn_time`; `btn_next` with `value_in`=23; `btn_next` with 59 -> one cycle with `time_ow`=1, `time_set`=`{23,59,0}`, `state`=IDLE.
- **Leap-year date:**
  - Date 24/2/29 (year, month, day) -> `date_ow`, `date_set`=`{29,2,24}`.
  - Repeating with year 23 -> `err` on day 29, `step` stays 2; then day 28 commits.
- **Range rejects:** ALRM with hour 24 -> `err`, `step`=0. Month 0 and month 13 -> `err`. Day 31 with month 4 -> `err`.
- **Abort:** TIME with hour 5 staged, then `btn_abort` together with `btn_next` -> IDLE, no `time_ow`, `time_set` unchanged.
- **Timeout:** `TIMEOUT_S`=3 in DATE, 3 `tick_1hz` with no buttons -> `timeout` pulse, IDLE, `date_set` unchanged. A `btn_next` on the 2nd tick restarts the count.
- **Priority and reset:**
  - `btn_time`+`btn_alarm` in the same cycle -> TIME.
  - `rst` asserted at step 1 -> IDLE, all outputs at reset values, no `*_ow`.
